// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - issue/operand-fetch stage with writeback bypass and RAW/WAW scoreboard
module operand_fetch #(
    parameter int REG_ADDR_SIZE = 5,
    parameter int REG_SIZE      = 32,
    parameter int NUM_REGS      = 32,
    parameter int ZERO_REG      = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [REG_ADDR_SIZE-1:0] InRsA,
    input  logic [REG_ADDR_SIZE-1:0] InRsB,
    input  logic [REG_ADDR_SIZE-1:0] InRd,
    input  logic                     InRdWrite,
    output logic [REG_ADDR_SIZE-1:0] RegA,
    output logic [REG_ADDR_SIZE-1:0] RegB,
    input  logic [REG_SIZE-1:0]      Data1,
    input  logic [REG_SIZE-1:0]      Data2,
    input  logic                     WbValid,
    input  logic [REG_ADDR_SIZE-1:0] WbReg,
    input  logic [REG_SIZE-1:0]      WbData,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [REG_SIZE-1:0]      OutOpA,
    output logic [REG_SIZE-1:0]      OutOpB,
    output logic [REG_ADDR_SIZE-1:0] OutRd,
    output logic                     OutRdWrite,
    output logic [31:0]              StallCount
);

    logic [NUM_REGS-1:0]      sb_q, sb_d, pend;
    logic                     out_valid_q, out_rd_write_q;
    logic [REG_SIZE-1:0]      out_op_a_q, out_op_b_q;
    logic [REG_ADDR_SIZE-1:0] out_rd_q;
    logic [31:0]              stall_q;
    logic                     hazard, accept;

    function automatic logic is_zero(input logic [REG_ADDR_SIZE-1:0] r);
        return (ZERO_REG != 0) && (r == '0);
    endfunction

    // The regfile write lands on the same edge we sample Data1/Data2, so forward it.
    function automatic logic [REG_SIZE-1:0] sel_op(
        input logic [REG_ADDR_SIZE-1:0] rs,
        input logic [REG_SIZE-1:0]      rf_data,
        input logic                     wb_valid,
        input logic [REG_ADDR_SIZE-1:0] wb_reg,
        input logic [REG_SIZE-1:0]      wb_data
    );
        if (wb_valid && (wb_reg == rs) && !is_zero(rs)) return wb_data;
        else if (is_zero(rs)) return '0;
        else return rf_data;
    endfunction

    always_comb begin
        pend = sb_q;
        if (WbValid) pend[WbReg] = 1'b0;
        if (ZERO_REG != 0) pend[0] = 1'b0;
    end

    assign hazard  = pend[InRsA] | pend[InRsB] | (InRdWrite & pend[InRd]);
    assign InReady = !hazard && (!out_valid_q || OutReady);
    assign accept  = InValid && InReady;

    // Clear before set so a same-cycle clear and re-set of one register leaves it pending.
    always_comb begin
        sb_d = sb_q;
        if (WbValid) sb_d[WbReg] = 1'b0;
        if (accept && InRdWrite && !is_zero(InRd)) sb_d[InRd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q           <= '0;
            out_valid_q    <= 1'b0;
            out_op_a_q     <= '0;
            out_op_b_q     <= '0;
            out_rd_q       <= '0;
            out_rd_write_q <= 1'b0;
            stall_q        <= '0;
        end else begin
            sb_q <= sb_d;
            if (accept) begin
                out_valid_q    <= 1'b1;
                out_op_a_q     <= sel_op(InRsA, Data1, WbValid, WbReg, WbData);
                out_op_b_q     <= sel_op(InRsB, Data2, WbValid, WbReg, WbData);
                out_rd_q       <= InRd;
                out_rd_write_q <= InRdWrite;
            end else if (OutReady) begin
                out_valid_q <= 1'b0;
            end
            if (InValid && hazard && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
        end
    end

    assign RegA       = InRsA;
    assign RegB       = InRsB;
    assign OutValid   = out_valid_q;
    assign OutOpA     = out_op_a_q;
    assign OutOpB     = out_op_b_q;
    assign OutRd      = out_rd_q;
    assign OutRdWrite = out_rd_write_q;
    assign StallCount = stall_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - scoreboard bench for operand_fetch
module tb_operand_fetch;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        w;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, InValid, InRdWrite, WbValid, OutReady;
    logic        InReady, OutValid, OutRdWrite;
    logic [4:0]  InRsA, InRsB, InRd, RegA, RegB, WbReg, OutRd;
    logic [31:0] Data1, Data2, WbData, OutOpA, OutOpB, StallCount;
    logic [31:0] rf [32];

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady),
        .InRsA(InRsA), .InRsB(InRsB), .InRd(InRd), .InRdWrite(InRdWrite),
        .RegA(RegA), .RegB(RegB), .Data1(Data1), .Data2(Data2),
        .WbValid(WbValid), .WbReg(WbReg), .WbData(WbData),
        .OutValid(OutValid), .OutReady(OutReady), .OutOpA(OutOpA), .OutOpB(OutOpB),
        .OutRd(OutRd), .OutRdWrite(OutRdWrite), .StallCount(StallCount)
    );

    assign Data1 = rf[RegA];
    assign Data2 = rf[RegB];

    always @(posedge clk) if (WbValid) rf[WbReg] <= WbData;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs are stable at the falling edge, so a transfer seen here completes on the next rise.
    always @(negedge clk) begin
        if (!reset && OutValid && OutReady) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk($sformatf("opA rd=%0d", e.rd), OutOpA, e.a);
                chk($sformatf("opB rd=%0d", e.rd), OutOpB, e.b);
                chk($sformatf("rd rd=%0d", e.rd), {27'd0, OutRd}, {27'd0, e.rd});
                chk($sformatf("rdw rd=%0d", e.rd), {31'd0, OutRdWrite}, {31'd0, e.w});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                         input logic w, input logic [31:0] ea, input logic [31:0] eb);
        exp_t e;
        InRsA = a; InRsB = b; InRd = d; InRdWrite = w; InValid = 1'b1;
        e.a = ea; e.b = eb; e.rd = d; e.w = w;
        exp_q.push_back(e);
    endtask

    task automatic wait_accept(input string name, input int budget);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (InReady) begin
                ok = 1'b1;
                break;
            end
        end
        chk({"accept_", name}, {31'd0, ok}, 32'd1);
        tick();
        InValid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
        rf[3] = 32'h11;
        rf[4] = 32'h22;
        reset = 1'b1; InValid = 1'b0; InRsA = '0; InRsB = '0; InRd = '0; InRdWrite = 1'b0;
        WbValid = 1'b0; WbReg = '0; WbData = '0; OutReady = 1'b1;
        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_outvalid", {31'd0, OutValid}, 32'd0);
        chk("rst_opa", OutOpA, 32'd0);
        chk("rst_opb", OutOpB, 32'd0);
        chk("rst_rd", {27'd0, OutRd}, 32'd0);
        chk("rst_stall", StallCount, 32'd0);
        chk("rst_inready", {31'd0, InReady}, 32'd1);
        tick();

        drive(5'd3, 5'd4, 5'd5, 1'b1, 32'h11, 32'h22);
        wait_accept("basic", 3);

        drive(5'd5, 5'd4, 5'd6, 1'b1, 32'hABCD, 32'h22);
        @(negedge clk); chk("raw_ready0", {31'd0, InReady}, 32'd0);
        @(negedge clk); chk("raw_ready1", {31'd0, InReady}, 32'd0); chk("raw_stall1", StallCount, 32'd1);
        @(negedge clk); chk("raw_ready2", {31'd0, InReady}, 32'd0); chk("raw_stall2", StallCount, 32'd2);
        tick();
        WbValid = 1'b1; WbReg = 5'd5; WbData = 32'hABCD;
        wait_accept("raw_bypass", 1);
        WbReg = 5'd6; WbData = 32'h66;
        @(negedge clk); chk("raw_stall_final", StallCount, 32'd3);
        tick();
        WbValid = 1'b0;

        drive(5'd1, 5'd2, 5'd7, 1'b1, 32'h101, 32'h102);
        wait_accept("waw_first", 3);
        drive(5'd2, 5'd1, 5'd7, 1'b1, 32'h102, 32'h101);
        @(negedge clk); chk("waw_ready0", {31'd0, InReady}, 32'd0);
        tick();
        @(negedge clk); chk("waw_ready1", {31'd0, InReady}, 32'd0); chk("waw_stall", StallCount, 32'd4);
        tick();
        WbValid = 1'b1; WbReg = 5'd7; WbData = 32'h77;
        wait_accept("waw_release", 1);
        WbValid = 1'b0;
        drive(5'd7, 5'd0, 5'd8, 1'b0, 32'h78, 32'h0);
        @(negedge clk); chk("set_wins_ready", {31'd0, InReady}, 32'd0); chk("set_wins_stall", StallCount, 32'd5);
        tick();
        WbValid = 1'b1; WbReg = 5'd7; WbData = 32'h78;
        wait_accept("set_wins_release", 1);
        WbValid = 1'b0;
        @(negedge clk); chk("stall_after_waw", StallCount, 32'd6);
        tick();

        OutReady = 1'b0;
        drive(5'd1, 5'd2, 5'd9, 1'b1, 32'h101, 32'h102);
        wait_accept("bp_first", 3);
        drive(5'd3, 5'd4, 5'd10, 1'b0, 32'h11, 32'h22);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("bp_ready%0d", i), {31'd0, InReady}, 32'd0);
            chk($sformatf("bp_valid%0d", i), {31'd0, OutValid}, 32'd1);
            chk($sformatf("bp_opa%0d", i), OutOpA, 32'h101);
            chk($sformatf("bp_rd%0d", i), {27'd0, OutRd}, 32'd9);
            chk($sformatf("bp_stall%0d", i), StallCount, 32'd6);
        end
        tick();
        OutReady = 1'b1;
        wait_accept("bp_release", 1);

        drive(5'd0, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0);
        wait_accept("zero_wr", 2);
        drive(5'd0, 5'd4, 5'd11, 1'b0, 32'h0, 32'h22);
        WbValid = 1'b1; WbReg = 5'd0; WbData = 32'hFFFF;
        wait_accept("zero_rd", 1);
        WbValid = 1'b0;
        @(negedge clk); chk("zero_stall", StallCount, 32'd6);
        tick();

        OutReady = 1'b0;
        drive(5'd1, 5'd2, 5'd5, 1'b1, 32'h101, 32'h102);
        wait_accept("pre_reset", 3);
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        OutReady = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", {31'd0, OutValid}, 32'd0);
        chk("mid_rst_stall", StallCount, 32'd0);
        chk("mid_rst_opa", OutOpA, 32'd0);
        chk("mid_rst_rdw", {31'd0, OutRdWrite}, 32'd0);
        tick();
        drive(5'd5, 5'd9, 5'd12, 1'b0, 32'hABCD, 32'h109);
        wait_accept("post_reset", 1);
        tick(); tick(); tick();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Issue/operand-fetch stage directly upstream of the register file.
- Accepts decoded instructions over a valid/ready handshake and drives the regfile read addresses.
- Captures both operands into an output pipeline register, with bypass from the writeback bus.
- Tracks outstanding destination writes in a per-register scoreboard and stalls issue on RAW/WAW hazards.

Parameters:
- REG_ADDR_SIZE, 5, register address width (matches constants.svh).
- REG_SIZE, 32, register data width.
- NUM_REGS, 32, number of architectural registers (2**REG_ADDR_SIZE).
- ZERO_REG, 1, when 1 register 0 reads as 0, is never pending and its writes are ignored by the scoreboard.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- InValid  in  1  decoded instruction valid
- InReady  out  1  stage can accept instruction this cycle
- InRsA  in  REG_ADDR_SIZE  source register A
- InRsB  in  REG_ADDR_SIZE  source register B
- InRd  in  REG_ADDR_SIZE  destination register
- InRdWrite  in  1  instruction writes InRd
- RegA  out  REG_ADDR_SIZE  regfile read address A (= InRsA, combinational)
- RegB  out  REG_ADDR_SIZE  regfile read address B (= InRsB, combinational)
- Data1  in  REG_SIZE  regfile read data A (combinational from RegA)
- Data2  in  REG_SIZE  regfile read data B
- WbValid  in  1  writeback occurring this cycle (same signal that drives regfile WriteEnable)
- WbReg  in  REG_ADDR_SIZE  writeback destination
- WbData  in  REG_SIZE  writeback data
- OutValid  out  1  output register holds valid instruction
- OutReady  in  1  downstream accepts
- OutOpA  out  REG_SIZE  operand A
- OutOpB  out  REG_SIZE  operand B
- OutRd  out  REG_ADDR_SIZE  destination
- OutRdWrite  out  1  destination write flag
- StallCount  out  32  saturating count of hazard-stall cycles

Behaviour:
- Reset (synchronous, highest priority, also mid-operation):
  - OutValid=0, OutOpA=0, OutOpB=0, OutRd=0, OutRdWrite=0.
  - Scoreboard all clear; StallCount=0.
  - An in-flight instruction is dropped.
- Pending(r):
  - Scoreboard bit r is set and NOT (WbValid && WbReg==r).
  - Always 0 for r=0 when ZERO_REG=1.
- Hazard:
  - Pending(InRsA) or Pending(InRsB), or (InRdWrite && Pending(InRd)).
  - Sources are checked regardless of use.
- InReady = !Hazard && (!OutValid || OutReady). It may depend on InValid-independent inputs only; it never depends on InValid.
- Accept = InValid && InReady. On accept, the output register loads next cycle (1-cycle latency):
  - OutValid=1, OutRd=InRd, OutRdWrite=InRdWrite.
  - OutOpA = WbData if WbValid && WbReg==InRsA && InRsA!=0(ZERO_REG); else 0 if InRsA==0 and ZERO_REG; else Data1. OutOpB is computed the same way with Data2.
  - The bypass is required because a regfile write lands on the same edge.
- If OutValid && OutReady && !Accept, then OutValid<=0. If !OutReady, the output holds all fields stable.
- Scoreboard update per cycle:
  - Clear bit WbReg when WbValid.
  - Set bit InRd when Accept && InRdWrite (and InRd!=0 under ZERO_REG).
  - Same register set and cleared in the same cycle: set wins.
- WbValid for a register whose bit is clear is legal; the bit stays clear.
- StallCount increments when InValid && Hazard, and saturates at 0xFFFFFFFF. Backpressure-only stalls (OutReady=0) are not counted.
- The handshake must not allow two outstanding writes to one register (guaranteed by the WAW check).

Test Plan:
- Reset then issue Rs=3,4 with regfile r3=0x11, r4=0x22, Rd=5 write -> next cycle OutValid=1, OutOpA=0x11, OutOpB=0x22, OutRd=5; scoreboard bit 5 set.
- RAW: after the above, issue RsA=5 with no writeback -> InReady=0 and StallCount increments each cycle. Then pulse WbValid, WbReg=5, WbData=0xABCD -> accepted that same cycle, OutOpA=0xABCD (bypass).
- WAW: Rd=7 pending, new instruction with Rd=7 -> stalls until WbReg=7 writeback, then accepted and bit 7 set again (set wins).
- Backpressure: OutReady=0 with OutValid=1 -> InReady=0, outputs stable for 3 cycles, StallCount unchanged. Raise OutReady -> next instruction accepted in the same cycle.
- ZERO_REG: Rd=0 write, then RsA=0 -> no stall, OutOpA=0, even with WbValid, WbReg=0, WbData=0xFFFF.
- Reset asserted while OutValid=1 and bits 5 and 9 set -> next cycle OutValid=0, scoreboard clear, and an instruction reading r5 issues without stall.
